// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT_CYC cycles.
module apb_master_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_SLAVES   = 4,
    parameter int unsigned SLV_ADDR_LSB = 12,
    parameter int unsigned TIMEOUT_CYC  = 16
) (
    input  logic                        i_pclk,
    input  logic                        i_preset,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic [NUM_REQ-1:0]          i_req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] i_req_strb,
    input  logic [NUM_REQ-1:0]          i_req_prot,
    output logic [NUM_REQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]           o_rsp_rdata,
    output logic                        o_rsp_err,
    output logic [NUM_SLAVES-1:0]       o_psel,
    output logic                        o_penable,
    output logic                        o_pwrite,
    output logic [ADDR_W-1:0]           o_paddr,
    output logic [DATA_W-1:0]           o_pwdata,
    output logic [DATA_W/8-1:0]         o_pstrb,
    output logic                        o_pprot,
    input  logic                        i_pready,
    input  logic                        i_pslverr,
    input  logic [DATA_W-1:0]           i_prdata
);
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned SLV_IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [REQ_IDX_W-1:0] LAST_INIT = REQ_IDX_W'(NUM_REQ - 1);
`ifdef APB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`endif

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                 r_state;
    logic [REQ_IDX_W-1:0]   r_last;
    logic [REQ_IDX_W-1:0]   r_gnt;
    logic [NUM_SLAVES-1:0]  r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDR_W-1:0]      r_paddr;
    logic [DATA_W-1:0]      r_pwdata;
    logic [STRB_W-1:0]      r_pstrb;
    logic                   r_pprot;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_rdata;
    logic                   r_rsp_err;
`ifdef APB_TIMEOUT_EN
    logic [TMO_W-1:0]       r_tmo_cnt;
`endif

    logic                   w_any;
    logic [REQ_IDX_W-1:0]   w_gnt;
    logic [NUM_REQ-1:0]     w_gnt_oh;
    logic [NUM_REQ-1:0]     w_rsp_oh;
    logic [SLV_IDX_W-1:0]   w_slv_idx;
    logic [NUM_SLAVES-1:0]  w_psel_dec;
    logic                   w_in_range;

    function automatic logic [REQ_IDX_W-1:0] rr_idx(input logic [REQ_IDX_W-1:0] base,
                                                    input int unsigned k);
        return REQ_IDX_W'((32'(base) + k) % NUM_REQ);
    endfunction

    // Scan from lowest to highest priority so the nearest requester after r_last wins.
    always_comb begin
        w_gnt = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            if (i_req_valid[rr_idx(r_last, k)]) w_gnt = rr_idx(r_last, k);
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        w_rsp_oh = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            w_gnt_oh[r] = (w_gnt == REQ_IDX_W'(r));
            w_rsp_oh[r] = (r_gnt == REQ_IDX_W'(r));
        end
    end

    // An out-of-range slave index decodes to an all-zero select.
    assign w_slv_idx = i_req_addr[w_gnt*ADDR_W + SLV_ADDR_LSB +: SLV_IDX_W];
    always_comb begin
        w_psel_dec = '0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            w_psel_dec[s] = (w_slv_idx == SLV_IDX_W'(s));
        end
    end
    assign w_in_range = |w_psel_dec;
    assign w_any      = |i_req_valid;

    assign o_req_ready = (r_state == StIdle && w_any && !i_preset) ? w_gnt_oh : '0;

    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_state     <= StIdle;
            r_last      <= LAST_INIT;
            r_gnt       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            r_rsp_valid <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_gnt    <= w_gnt;
                        r_last   <= w_gnt;
                        r_pwrite <= i_req_write[w_gnt];
                        r_paddr  <= i_req_addr[w_gnt*ADDR_W +: ADDR_W];
                        r_pwdata <= i_req_wdata[w_gnt*DATA_W +: DATA_W];
                        r_pstrb  <= i_req_strb[w_gnt*STRB_W +: STRB_W];
                        r_pprot  <= i_req_prot[w_gnt];
                        if (w_in_range) begin
                            r_psel  <= w_psel_dec;
                            r_state <= StSetup;
                        end else begin
                            r_rsp_valid <= w_gnt_oh;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= StResp;
                        end
                    end
                end
                StSetup: begin
                    r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state   <= StAccess;
                end
                StAccess: begin
                    if (i_pready) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_rsp_oh;
                        r_rsp_err   <= i_pslverr;
                        r_rsp_rdata <= r_pwrite ? '0 : i_prdata;
                        r_state     <= StResp;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_rsp_oh;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= StResp;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                StResp: begin
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_psel      = r_psel;
    assign o_penable   = r_penable;
    assign o_pwrite    = r_pwrite;
    assign o_paddr     = r_paddr;
    assign o_pwdata    = r_pwdata;
    assign o_pstrb     = r_pstrb;
    assign o_pprot     = r_pprot;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: timestamp-based transaction model plus
// directed scenarios and randomized requesters/slave.
module tb_apb_master_arbiter;
    localparam int NR  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int NS  = 3;
    localparam int LSB = 12;
    localparam int TMO = 16;

    logic              pclk, preset;
    logic [NR-1:0]     req_valid, req_ready, req_write, req_prot, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SW-1:0]  req_strb;
    logic [DW-1:0]     rsp_rdata, pwdata, prdata;
    logic              rsp_err, penable, pwrite, pprot, pready, pslverr;
    logic [NS-1:0]     psel;
    logic [AW-1:0]     paddr;
    logic [SW-1:0]     pstrb;

    apb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS),
        .SLV_ADDR_LSB(LSB), .TIMEOUT_CYC(TMO)
    ) dut (
        .i_pclk(pclk), .i_preset(preset),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_strb(req_strb),
        .i_req_prot(req_prot), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
        .o_paddr(paddr), .o_pwdata(pwdata), .o_pstrb(pstrb), .o_pprot(pprot),
        .i_pready(pready), .i_pslverr(pslverr), .i_prdata(prdata)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got no event within cycle budget, expected event", nm);
    endtask

    // ---------------- transaction-level model ----------------
    int            cyc = 0;
    bit            m_busy = 0;
    int            m_g = 0, m_tg = 0, m_tend = -1, m_trsp = -1, m_slv = 0;
    bit            m_oor = 0;
    int            m_last = NR - 1;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [SW-1:0] m_strb = '0;
    bit            m_write = 0, m_prot = 0;
    logic [NR-1:0] m_acc = '0;

    // DUT observations used by the directed literal checks
    int            mon_grant_cyc = 0, mon_rsp_cyc = 0, mon_rsp_cnt = 0;
    int            mon_psel_cnt = 0, mon_pen_cnt = 0;
    logic [NR-1:0] mon_rsp_vec = '0;
    logic [DW-1:0] mon_rdata = '0;
    logic          mon_err = 1'b0;
    logic [NS-1:0] mon_psel_val = '0;
    int            mon_gq[$];

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    initial begin
        logic [NR-1:0] e_ready, e_rsp;
        logic [NS-1:0] e_psel;
        logic          e_pen, live;
        int            p;
        forever begin
            @(negedge pclk);
            e_ready = '0; e_rsp = '0; e_psel = '0; e_pen = 1'b0; p = -1;
            if (preset) begin
                m_busy = 0; m_last = NR - 1; m_trsp = -1;
                m_addr = '0; m_wdata = '0; m_strb = '0; m_write = 0; m_prot = 0;
            end else if (!m_busy) begin
                p = rr_pick(req_valid, m_last);
                if (p >= 0) e_ready[p] = 1'b1;
            end else begin
                live = !m_oor && (m_tend < 0 || cyc <= m_tend);
                if (live && cyc > m_tg) e_psel[m_slv] = 1'b1;
                if (live && cyc >= m_tg + 2) e_pen = 1'b1;
                if (cyc == m_trsp) e_rsp[m_g] = 1'b1;
            end
            chk("req_ready", req_ready, e_ready);
            chk("psel", psel, e_psel);
            chk("penable", penable, e_pen);
            chk("rsp_valid", rsp_valid, e_rsp);
            chk("paddr", paddr, m_addr);
            chk("pwrite", pwrite, m_write);
            chk("pwdata", pwdata, m_wdata);
            chk("pstrb", pstrb, m_strb);
            chk("pprot", pprot, m_prot);
            if (preset) begin
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_rsp_err", rsp_err, 0);
            end else if (e_rsp != 0) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", rsp_err, m_err);
            end

            if (req_ready != 0) begin
                mon_grant_cyc = cyc;
                for (int r = NR - 1; r >= 0; r--) if (req_ready[r]) p = r;
                mon_gq.push_back(p);
            end
            if (rsp_valid != 0) begin
                mon_rsp_cyc = cyc; mon_rsp_cnt++; mon_rsp_vec = rsp_valid;
                mon_rdata = rsp_rdata; mon_err = rsp_err;
            end
            if (psel != 0) begin mon_psel_cnt++; mon_psel_val = psel; end
            if (penable) mon_pen_cnt++;

            // advance the model over the cycle that ends at the next rising edge
            m_acc = '0;
            if (!preset) begin
                if (!m_busy) begin
                    p = rr_pick(req_valid, m_last);
                    if (p >= 0) begin
                        m_busy = 1; m_g = p; m_tg = cyc; m_last = p; m_acc[p] = 1'b1;
                        m_addr  = req_addr[p*AW +: AW];
                        m_wdata = req_wdata[p*DW +: DW];
                        m_strb  = req_strb[p*SW +: SW];
                        m_write = req_write[p];
                        m_prot  = req_prot[p];
                        m_slv   = int'((m_addr >> LSB) % (1 << $clog2(NS)));
                        m_oor   = (m_slv >= NS);
                        m_tend  = -1;
                        m_trsp  = m_oor ? cyc + 1 : -1;
                        if (m_oor) begin m_rdata = '0; m_err = 1; end
                    end
                end else if (cyc == m_trsp) begin
                    m_busy = 0;
                end else if (!m_oor && m_tend < 0 && cyc >= m_tg + 2) begin
                    if (pready) begin
                        m_tend = cyc; m_trsp = cyc + 1;
                        m_rdata = m_write ? '0 : prdata; m_err = pslverr;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (cyc == m_tg + 1 + TMO) begin
                        m_tend = cyc; m_trsp = cyc + 1; m_rdata = '0; m_err = 1;
                    end
`endif
                end
            end
            cyc++;
        end
    end

    // ---------------- APB slave ----------------
    int            sl_mode = 0;  // 0: fixed wait states, 1: random, 2: never ready
    int            sl_wait = 0;
    logic [DW-1:0] sl_rdata = '0;
    logic          sl_err = 1'b0;

    initial begin
        int wcnt;
        wcnt = 0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(posedge pclk);
            #1;
            if (sl_mode == 1) begin
                pready  = ($urandom_range(2) == 0);
                pslverr = ($urandom_range(3) == 0);
                prdata  = $urandom;
            end else begin
                prdata = sl_rdata; pslverr = sl_err;
                if (sl_mode == 0 && penable && !preset) begin
                    pready = (wcnt >= sl_wait);
                    wcnt   = pready ? 0 : wcnt + 1;
                end else begin
                    pready = 1'b0; wcnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input int r, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] st, input bit pr);
        req_write[r] = wr; req_prot[r] = pr;
        req_addr[r*AW +: AW] = a; req_wdata[r*DW +: DW] = wd; req_strb[r*SW +: SW] = st;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_acc(input int r, input string nm);
        int k;
        for (k = 0; k < 100; k++) begin
            step();
            if (m_acc[r]) break;
        end
        if (k == 100) bound_fail(nm);
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int base, input string nm);
        int k;
        for (k = 0; k < 100; k++) begin
            step();
            if (mon_rsp_cnt > base) break;
        end
        if (k == 100) bound_fail(nm);
    endtask

    task automatic wait_grants(input int want, input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            step();
            if (mon_gq.size() >= want) break;
        end
        if (k == 200) bound_fail(nm);
    endtask

    initial begin
        int rc, pc, ec, gb, k;
        #1000000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, pc, ec, gb, k;
        preset = 1'b1;
        req_valid = '0; req_write = '0; req_prot = '0;
        req_addr = '0; req_wdata = '0; req_strb = '0;
        repeat (3) step();
        chk("reset_psel", psel, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_paddr", paddr, 0);
        preset = 1'b0;
        step();

        // single read, zero wait states
        sl_mode = 0; sl_wait = 0; sl_rdata = 32'hDEAD_BEEF; sl_err = 1'b0;
        rc = mon_rsp_cnt; pc = mon_psel_cnt;
        issue(0, 0, 32'h0000_2010, 32'h0, 4'hF, 0);
        wait_acc(0, "rd_grant");
        wait_rsp(rc, "rd_rsp");
        chk("rd_latency", mon_rsp_cyc - mon_grant_cyc, 3);
        chk("rd_rsp_vec", mon_rsp_vec, 3'b001);
        chk("rd_rdata", mon_rdata, 32'hDEAD_BEEF);
        chk("rd_err", mon_err, 0);
        chk("rd_psel_cycles", mon_psel_cnt - pc, 2);
        chk("rd_psel_val", mon_psel_val, 3'b100);

        // write with three wait states
        step();
        sl_wait = 3;
        rc = mon_rsp_cnt; ec = mon_pen_cnt;
        issue(1, 1, 32'h0000_1004, 32'h1234_5678, 4'b0011, 1);
        wait_acc(1, "wr_grant");
        wait_rsp(rc, "wr_rsp");
        chk("wr_penable_cycles", mon_pen_cnt - ec, 4);
        chk("wr_latency", mon_rsp_cyc - mon_grant_cyc, 6);
        chk("wr_rsp_vec", mon_rsp_vec, 3'b010);
        chk("wr_rdata", mon_rdata, 0);
        chk("wr_pwdata_hold", pwdata, 32'h1234_5678);
        chk("wr_pstrb_hold", pstrb, 4'b0011);

        // two requesters held continuously
        step();
        sl_wait = 1;
        rc = mon_rsp_cnt; gb = mon_gq.size();
        issue(0, 0, 32'h0000_0000, 32'h0, 4'hF, 0);
        issue(1, 1, 32'h0000_2008, 32'hCAFE_0001, 4'hF, 0);
        wait_grants(gb + 4, "alt_grants");
        req_valid = '0;
        repeat (10) step();
        for (int i = 0; i < 4; i++) begin
            k = (gb + i < mon_gq.size()) ? mon_gq[gb + i] : -1;
            chk($sformatf("alt_order_%0d", i), k, i % 2);
        end
        chk("alt_rsp_count", mon_rsp_cnt - rc, 4);

        // out-of-range slave index
        rc = mon_rsp_cnt; pc = mon_psel_cnt;
        issue(2, 0, 32'h0000_3000, 32'h0, 4'hF, 0);
        wait_acc(2, "oor_grant");
        wait_rsp(rc, "oor_rsp");
        chk("oor_latency", mon_rsp_cyc - mon_grant_cyc, 1);
        chk("oor_rsp_vec", mon_rsp_vec, 3'b100);
        chk("oor_err", mon_err, 1);
        chk("oor_rdata", mon_rdata, 0);
        chk("oor_psel_cycles", mon_psel_cnt - pc, 0);

        // ACCESS phase that needs many wait states (or times out)
        step();
`ifdef APB_TIMEOUT_EN
        sl_mode = 2;
`else
        sl_wait = 20;
`endif
        sl_err = 1'b1; sl_rdata = 32'hA5A5_0001;
        rc = mon_rsp_cnt; ec = mon_pen_cnt;
        issue(0, 0, 32'h0000_1000, 32'h0, 4'hF, 0);
        wait_acc(0, "long_grant");
        wait_rsp(rc, "long_rsp");
        chk("long_err", mon_err, 1);
`ifdef APB_TIMEOUT_EN
        chk("tmo_latency", mon_rsp_cyc - mon_grant_cyc, 18);
        chk("tmo_penable_cycles", mon_pen_cnt - ec, 16);
        chk("tmo_rdata", mon_rdata, 0);
`else
        chk("long_latency", mon_rsp_cyc - mon_grant_cyc, 23);
        chk("long_penable_cycles", mon_pen_cnt - ec, 21);
        chk("long_rdata", mon_rdata, 32'hA5A5_0001);
`endif
        sl_mode = 0; sl_wait = 0; sl_err = 1'b0;

        // reset during ACCESS
        step();
        sl_mode = 2;
        issue(0, 0, 32'h0000_0020, 32'h0, 4'hF, 0);
        wait_acc(0, "rst_grant");
        repeat (3) step();
        rc = mon_rsp_cnt;
        preset = 1'b1;
        #1;
        chk("rst_now_psel", psel, 0);
        chk("rst_now_penable", penable, 0);
        chk("rst_now_rsp_valid", rsp_valid, 0);
        step();
        step();
        preset = 1'b0;
        sl_mode = 0;
        repeat (3) step();
        chk("rst_no_rsp", mon_rsp_cnt - rc, 0);
        gb = mon_gq.size();
        issue(0, 0, 32'h0000_0040, 32'h0, 4'hF, 0);
        issue(1, 0, 32'h0000_0044, 32'h0, 4'hF, 0);
        wait_grants(gb + 2, "rst_regrant");
        req_valid = '0;
        k = (gb < mon_gq.size()) ? mon_gq[gb] : -1;
        chk("rst_first_grant", k, 0);
        k = (gb + 1 < mon_gq.size()) ? mon_gq[gb + 1] : -1;
        chk("rst_second_grant", k, 1);
        repeat (6) step();

        // randomized traffic
        sl_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (req_valid[r] && m_acc[r]) begin
                    req_valid[r] = 1'b0;
                    if ($urandom_range(1) == 1)
                        issue(r, 1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom));
                end else if (!req_valid[r]) begin
                    if ($urandom_range(2) == 0)
                        issue(r, 1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom));
                end else if ($urandom_range(15) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            step();
        end
        req_valid = '0;
        for (k = 0; k < 200; k++) begin
            step();
            if (!m_busy) break;
        end
        if (k == 200) bound_fail("drain");
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
